// File: rtl/demux_pares_tarea34.sv
`default_nettype none
// ============================================================================
// Module   : demux_pares_tarea34
// Purpose  : Reverses a 2:1 word interleave. A lane-0 word followed by a
//            lane-1 word is delivered as one parallel pair on registered
//            outputs, with a tag-sequence error pulse and a pair counter.
// Revision : 1.0 - initial release
// ============================================================================
module demux_pares_tarea34 #(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic              selector_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out,
  output logic              error_sec,
  output logic [CNT_W-1:0]  contador_pares
);

  // ESPERA_0: waiting for a lane-0 word.
  // ESPERA_1: lane-0 word held in r_buf0, waiting for its lane-1 partner.
  typedef enum logic [0:0] {
    ESPERA_0 = 1'b0,
    ESPERA_1 = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_buf0;
  logic [DATA_W-1:0]   w_buf0_nxt;
  logic [DATA_W-1:0]   r_data_out0;
  logic [DATA_W-1:0]   w_data_out0_nxt;
  logic [DATA_W-1:0]   r_data_out1;
  logic [DATA_W-1:0]   w_data_out1_nxt;
  logic                r_valid_out;
  logic                w_valid_out_nxt;
  logic                r_error_sec;
  logic                w_error_sec_nxt;
  logic [CNT_W-1:0]    r_contador;
  logic [CNT_W-1:0]    w_contador_nxt;

  // State, buffer and output registers; reset clears everything at once,
  // including any half-received pair.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ESPERA_0;
      r_buf0      <= '0;
      r_data_out0 <= '0;
      r_data_out1 <= '0;
      r_valid_out <= 1'b0;
      r_error_sec <= 1'b0;
      r_contador  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf0      <= w_buf0_nxt;
      r_data_out0 <= w_data_out0_nxt;
      r_data_out1 <= w_data_out1_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_error_sec <= w_error_sec_nxt;
      r_contador  <= w_contador_nxt;
    end
  end

  // Next-state and next-output decode. Pulses default low and data/counter
  // default to holding, so idle cycles change nothing visible.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf0_nxt      = r_buf0;
    w_data_out0_nxt = r_data_out0;
    w_data_out1_nxt = r_data_out1;
    w_valid_out_nxt = 1'b0;
    w_error_sec_nxt = 1'b0;
    w_contador_nxt  = r_contador;

    if (valid_in) begin
      case (r_state)
        ESPERA_0: begin
          if (!selector_in) begin
            w_buf0_nxt  = data_in;
            w_state_nxt = ESPERA_1;
          end else begin
            // Lane-1 word with no lane-0 partner: drop it.
            w_error_sec_nxt = 1'b1;
          end
        end
        ESPERA_1: begin
          if (selector_in) begin
            w_data_out0_nxt = r_buf0;
            w_data_out1_nxt = data_in;
            w_valid_out_nxt = 1'b1;
            w_contador_nxt  = r_contador + 1'b1;
            w_state_nxt     = ESPERA_0;
          end else begin
            // Second lane-0 word in a row: resync on the newest one.
            w_buf0_nxt      = data_in;
            w_error_sec_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ESPERA_0;
        end
      endcase
    end
  end

  assign data_out0      = r_data_out0;
  assign data_out1      = r_data_out1;
  assign valid_out      = r_valid_out;
  assign error_sec      = r_error_sec;
  assign contador_pares = r_contador;

endmodule
`default_nettype wire

// File: tb/tb_demux_pares_tarea34.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_pares_tarea34
// Purpose  : Directed self-checking bench for demux_pares_tarea34.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_pares_tarea34;

  localparam int DATA_W = 2;
  localparam int CNT_W  = 5;

  logic              clk;
  logic              reset_L;
  logic              valid_in;
  logic              selector_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out;
  logic              error_sec;
  logic [CNT_W-1:0]  contador_pares;

  int n_assert;
  int n_fail;

  demux_pares_tarea34 #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .valid_in      (valid_in),
    .selector_in   (selector_in),
    .data_in       (data_in),
    .data_out0     (data_out0),
    .data_out1     (data_out1),
    .valid_out     (valid_out),
    .error_sec     (error_sec),
    .contador_pares(contador_pares)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check every output in one call.
  task automatic chk_all(input string tag, input logic [DATA_W-1:0] d0,
                         input logic [DATA_W-1:0] d1, input logic v,
                         input logic e, input logic [CNT_W-1:0] c);
    chk({tag, ".data_out0"}, 32'(data_out0), 32'(d0));
    chk({tag, ".data_out1"}, 32'(data_out1), 32'(d1));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(v));
    chk({tag, ".error_sec"}, 32'(error_sec), 32'(e));
    chk({tag, ".contador"},  32'(contador_pares), 32'(c));
  endtask

  // Present one word for one rising edge; returns 1 ns after that edge,
  // when the outputs reflect this word.
  task automatic send(input logic sel, input logic [DATA_W-1:0] d);
    valid_in    = 1'b1;
    selector_in = sel;
    data_in     = d;
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [CNT_W-1:0]  cnt;
    int                pulses;

    n_assert    = 0;
    n_fail      = 0;
    valid_in    = 1'b0;
    selector_in = 1'b0;
    data_in     = '0;
    reset_L     = 1'b1;

    // Asynchronous reset before the first clock edge.
    #1 reset_L = 1'b0;
    #1;
    chk_all("reset_async", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    idle();
    idle();
    @(negedge clk);
    reset_L = 1'b1;
    idle();
    chk_all("reset_release", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);

    // Basic pair 10/01.
    send(1'b0, 2'b10);
    chk_all("pair1_lane0", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    send(1'b1, 2'b01);
    chk_all("pair1_out", 2'b10, 2'b01, 1'b1, 1'b0, 5'd1);
    idle();
    chk_all("pair1_hold", 2'b10, 2'b01, 1'b0, 1'b0, 5'd1);

    // Two lane-0 words: error, resync on the second.
    send(1'b0, 2'b01);
    send(1'b0, 2'b10);
    chk_all("dup0_err", 2'b10, 2'b01, 1'b0, 1'b1, 5'd1);
    send(1'b1, 2'b11);
    chk_all("dup0_pair", 2'b10, 2'b11, 1'b1, 1'b0, 5'd2);

    // Idle gap inside a pair.
    send(1'b0, 2'b01);
    idle();
    chk_all("gap_idle1", 2'b10, 2'b11, 1'b0, 1'b0, 5'd2);
    idle();
    idle();
    chk_all("gap_idle3", 2'b10, 2'b11, 1'b0, 1'b0, 5'd2);
    send(1'b1, 2'b10);
    chk_all("gap_pair", 2'b01, 2'b10, 1'b1, 1'b0, 5'd3);

    // 32 back-to-back pairs; counter walks through the wrap back to 3.
    cnt    = 5'd3;
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      d0 = DATA_W'(k);
      d1 = ~DATA_W'(k);
      send(1'b0, d0);
      chk("b2b_lane0_valid", 32'(valid_out), 32'd0);
      send(1'b1, d1);
      cnt = cnt + 5'd1;
      if (valid_out === 1'b1) pulses++;
      chk_all("b2b_pair", d0, d1, 1'b1, 1'b0, cnt);
    end
    chk("b2b_pulses", 32'(pulses), 32'd32);
    chk("b2b_cnt_wrap", 32'(contador_pares), 32'd3);

    // Reset mid-cycle while a lane-0 word is buffered.
    send(1'b0, 2'b11);
    @(posedge clk);
    #3 reset_L = 1'b0;
    #1;
    chk_all("midreset_async", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    reset_L = 1'b1;
    idle();
    send(1'b1, 2'b10);
    chk_all("midreset_orphan", 2'b00, 2'b00, 1'b0, 1'b1, 5'd0);

    // Orphan lane-1 word, then a clean 00/11 pair.
    send(1'b1, 2'b11);
    chk_all("orphan_err", 2'b00, 2'b00, 1'b0, 1'b1, 5'd0);
    send(1'b0, 2'b00);
    chk_all("orphan_lane0", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    send(1'b1, 2'b11);
    chk_all("orphan_pair", 2'b00, 2'b11, 1'b1, 1'b0, 5'd1);
    idle();
    chk_all("final_hold", 2'b00, 2'b11, 1'b0, 1'b0, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
